// File: rtl/mux_4_to_1.sv
// Registered 4-to-1 lane multiplexer with valid tracking and a select-change pulse.
// Define MUX_4TO1_PARITY_EN to add the registered even-parity output o_par.
module mux_4_to_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] a,
  input  logic [1:0]         s,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   o,
  output logic               out_valid,
  output logic [1:0]         s_q,
  output logic               sel_chg
`ifdef MUX_4TO1_PARITY_EN
  ,
  output logic               o_par
`endif
);

  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] o_d, o_q;
  logic [1:0]       sel_d, sel_q;
  logic             valid_d, valid_q;
  logic             chg_d, chg_q;
  logic             primed_d, primed_q;

  always_comb begin
    lane = a[0 +: WIDTH];
    unique case (s)
      2'd0: lane = a[0*WIDTH +: WIDTH];
      2'd1: lane = a[1*WIDTH +: WIDTH];
      2'd2: lane = a[2*WIDTH +: WIDTH];
      2'd3: lane = a[3*WIDTH +: WIDTH];
    endcase
  end

  // primed_q gates sel_chg so the first capture after reset never reports a switch.
  always_comb begin
    o_d      = o_q;
    sel_d    = sel_q;
    valid_d  = 1'b0;
    chg_d    = 1'b0;
    primed_d = primed_q;
    if (in_valid) begin
      o_d      = lane;
      sel_d    = s;
      valid_d  = 1'b1;
      chg_d    = primed_q && (s != sel_q);
      primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q      <= '0;
      sel_q    <= 2'b00;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      o_q      <= o_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      chg_q    <= chg_d;
      primed_q <= primed_d;
    end
  end

  assign o         = o_q;
  assign s_q       = sel_q;
  assign out_valid = valid_q;
  assign sel_chg   = chg_q;

`ifdef MUX_4TO1_PARITY_EN
  logic par_d, par_q;

  always_comb begin
    par_d = par_q;
    if (in_valid) begin
      par_d = ^lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign o_par = par_q;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Bench for mux_4_to_1: a 1-bit and an 8-bit instance share select/valid/reset and are
// checked every cycle against a lane-index model, plus hand-computed literal expectations.
module tb_mux_4_to_1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a1;
  logic [31:0] a8;
  logic [1:0]  s;
  logic        in_valid;

  logic [0:0]  o1;
  logic        ov1, chg1;
  logic [1:0]  sq1;
  logic [7:0]  o8;
  logic        ov8, chg8;
  logic [1:0]  sq8;
`ifdef MUX_4TO1_PARITY_EN
  logic        par1, par8;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .s         (s),
    .in_valid  (in_valid),
    .o         (o1),
    .out_valid (ov1),
    .s_q       (sq1),
    .sel_chg   (chg1)
`ifdef MUX_4TO1_PARITY_EN
    ,
    .o_par     (par1)
`endif
  );

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .s         (s),
    .in_valid  (in_valid),
    .o         (o8),
    .out_valid (ov8),
    .s_q       (sq8),
    .sel_chg   (chg8)
`ifdef MUX_4TO1_PARITY_EN
    ,
    .o_par     (par8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: lanes picked by shifting the packed bus; select history kept as plain ints.
  int   m_o1, m_o8, m_sq, m_last;
  bit   m_ov, m_chg, m_par, m_primed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_o1 = 0; m_o8 = 0; m_sq = 0; m_ov = 0; m_chg = 0; m_par = 0; m_primed = 0; m_last = 0;
    end else if (in_valid) begin
      m_o1     = (int'(a1) >> int'(s)) & 1;
      m_o8     = int'(a8 >> (int'(s) * 8)) & 8'hFF;
      m_par    = ($countones(m_o8) % 2) == 1;
      m_chg    = m_primed && (int'(s) != m_last);
      m_sq     = int'(s);
      m_last   = int'(s);
      m_ov     = 1;
      m_primed = 1;
    end else begin
      m_ov  = 0;
      m_chg = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("o1", 32'(o1), 32'(m_o1));
    chk("o8", 32'(o8), 32'(m_o8));
    chk("s_q8", 32'(sq8), 32'(m_sq));
    chk("s_q1", 32'(sq1), 32'(m_sq));
    chk("out_valid", 32'({ov1, ov8}), {30'd0, m_ov, m_ov});
    chk("sel_chg", 32'({chg1, chg8}), {30'd0, m_chg, m_chg});
`ifdef MUX_4TO1_PARITY_EN
    chk("o_par8", 32'(par8), 32'(m_par));
    chk("o_par1", 32'(par1), 32'(m_o1));
`endif
  end

  task automatic cyc(input logic v, input logic [1:0] sel);
    @(negedge clk);
    in_valid = v;
    s        = sel;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    s        = 2'b00;
    a1       = 4'b1010;
    a8       = 32'hD4C3B2A1;
    #12;
    chk("rst o8", 32'(o8), 32'h0);
    chk("rst flags", 32'({ov8, chg8, sq8}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Step through all lanes.
    cyc(1'b1, 2'b00);
    chk("lit o1 s0", 32'(o1), 32'h0);
    chk("lit o8 s0", 32'(o8), 32'hA1);
    chk("lit chg first", 32'(chg8), 32'h0);
    chk("lit valid", 32'(ov8), 32'h1);
    cyc(1'b1, 2'b01);
    chk("lit o1 s1", 32'(o1), 32'h1);
    chk("lit chg s1", 32'(chg8), 32'h1);
    chk("lit model o8 s1", 32'(m_o8), 32'hB2);
    cyc(1'b1, 2'b10);
    chk("lit o8 s2", 32'(o8), 32'hC3);
    chk("lit sq s2", 32'(sq8), 32'h2);
`ifdef MUX_4TO1_PARITY_EN
    chk("lit par C3", 32'(par8), 32'h0);
`endif
    cyc(1'b1, 2'b11);
    chk("lit o1 s3", 32'(o1), 32'h1);
    chk("lit o8 s3", 32'(o8), 32'hD4);
`ifdef MUX_4TO1_PARITY_EN
    chk("lit par D4", 32'(par8), 32'h0);
`endif

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst o8", 32'(o8), 32'h0);
    chk("async rst flags", 32'({ov8, chg8, sq8, o1}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 2'b11);
    chk("lit chg after rst", 32'(chg8), 32'h0);
    chk("lit sq after rst", 32'(sq8), 32'h3);

    // Invalid gap while s changes; compare resumes against last captured select.
    cyc(1'b1, 2'b01);
    cyc(1'b0, 2'b01);
    cyc(1'b0, 2'b11);
    cyc(1'b0, 2'b11);
    chk("lit gap hold o1", 32'(o1), 32'h1);
    chk("lit gap hold sq", 32'(sq8), 32'h1);
    chk("lit gap valid", 32'(ov8), 32'h0);
    cyc(1'b1, 2'b11);
    chk("lit chg after gap", 32'(chg8), 32'h1);

    // Hold s=10 for four captures.
    cyc(1'b1, 2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10);
    chk("lit hold chg", 32'(chg8), 32'h0);
    chk("lit hold o8", 32'(o8), 32'hC3);

    // New data on the same lane, then lane 0 for odd parity.
    @(negedge clk);
    a8 = 32'h12345678;
    cyc(1'b1, 2'b10);
    chk("lit new data", 32'(o8), 32'h34);
    a8 = 32'hD4C3B2A1;
    cyc(1'b1, 2'b00);
    chk("lit o8 A1", 32'(o8), 32'hA1);
`ifdef MUX_4TO1_PARITY_EN
    chk("lit par A1", 32'(par8), 32'h1);
`endif
    cyc(1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1.md
# mux_4_to_1

Registered 4-to-1 multiplexer selecting one of four WIDTH-bit lanes packed into a single input bus, under a 2-bit select. It serves as a generic lane-select stage in datapaths, with a one-cycle registered output and valid tracking. It also provides a select-change pulse so downstream logic can detect source switches.

## Interface
- WIDTH, 1, bit width of each lane and of the output.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- a  input  4*WIDTH  packed lanes; lane k = a[k*WIDTH +: WIDTH], lane 0 in the LSBs.
- s  input  2  lane select; 2'b00 selects lane 0, 2'b11 selects lane 3.
- in_valid  input  1  qualifies a and s for capture.
- o  output  WIDTH  registered selected lane.
- out_valid  output  1  o holds a value captured from a valid input.
- s_q  output  2  select value used for the current o.
- sel_chg  output  1  one-cycle pulse: the captured select differs from the previous captured select.
- o_par  output  1  even parity of o; exists only with MUX_4TO1_PARITY_EN.

## Operation
- On each rising clk with in_valid=1: o <= lane[s]; s_q <= s; out_valid <= 1.
- With in_valid=0: o and s_q hold; out_valid <= 0; sel_chg <= 0.
- sel_chg <= 1 iff in_valid=1, at least one earlier capture occurred since reset, and s != s_q. Otherwise sel_chg <= 0.
- The first capture after reset never asserts sel_chg. An internal "primed" flag is set on the first capture.
- All four select codes are legal. There is no error or out-of-range case.
- a and s are sampled only at clock edges. Glitches between edges have no effect.

## Timing
- Latency is exactly 1 cycle from the capturing edge to o, s_q, out_valid, sel_chg and o_par.
- Throughput is one selection per cycle. There is no backpressure.
- Reset (rst_n=0, asynchronous, immediate) drives o=0, s_q=2'b00, out_valid=0, sel_chg=0, o_par=0, and clears the primed flag.
- Reset asserted mid-stream discards the in-flight value. The first valid cycle after release behaves as a first capture, so sel_chg=0.
- If in_valid is high on the same edge that rst_n deasserts, the input is ignored. Capture starts on the next edge.
- Back-to-back valid cycles with the same s keep sel_chg=0. Each change in s across consecutive captures yields a 1-cycle sel_chg pulse.
- A change in s across an invalid gap is still compared against the last captured s_q.

## Configuration
- MUX_4TO1_PARITY_EN defined: the o_par port exists and is registered as ^lane[s] alongside o, with the same enable and reset (reset value 0).
- MUX_4TO1_PARITY_EN undefined: the o_par port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=1, a=4'b1010, in_valid=1, s stepping 00,01,10,11 once per cycle -> o next cycle = 0,1,0,1, and s_q follows s with 1-cycle lag.
- The same sequence -> sel_chg=0 on the first capture, then 1 on each of the three following captures. out_valid=1 throughout.
- Assert rst_n=0 between clock edges -> o, s_q, out_valid and sel_chg go to 0 immediately. First capture after release gives sel_chg=0.
- in_valid=0 for 3 cycles while s changes 01->11 -> o and s_q hold, out_valid=0. Next valid with s=11 vs s_q=01 -> sel_chg=1.
- WIDTH=8, a={8'hD4,8'hC3,8'hB2,8'hA1}, s=10 -> o=8'hC3. With MUX_4TO1_PARITY_EN defined, o_par=0; s=11 -> o=8'hD4, o_par=0; s=00 -> o=8'hA1, o_par=1.
- Holding s=10 valid for 4 cycles -> sel_chg stays 0 after the first change, and o is stable.
